// File: rtl/alu_div_seq_if.sv
// rtl/alu_div_seq_if.sv - launch/result handshake bundle between a controller and alu_div_seq
interface alu_div_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;

  modport master (
    output start, A, B,
    input  busy, done, Q, R, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R, div_by_zero
  );
endinterface

// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - multi-cycle unsigned restoring divider (quotient, remainder, zero flag)
module alu_div_seq #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  alu_div_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic             zflag;
  logic [WIDTH-1:0] q_r, r_r;
  logic             z_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_diff;

  assign shifted     = {rem, quo[WIDTH-1]};
  assign diff        = {1'b0, shifted} - {2'b00, dvs};
  assign unused_diff = diff[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Zero divisor still passes through RUN once with count=0, so its result lands one edge after launch
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (count == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      RUN:     bus.busy = 1'b1;
      DONE:    begin bus.busy = 1'b1; bus.done = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      zflag <= 1'b0;
      q_r   <= '0;
      r_r   <= '0;
      z_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          quo   <= bus.A;
          rem   <= '0;
          dvs   <= bus.B;
          zflag <= (bus.B == '0);
          count <= (bus.B == '0) ? '0 : CW'(WIDTH);
        end
        RUN: if (count == '0) begin
          q_r <= zflag ? '1 : quo;
          r_r <= zflag ? quo : rem;
          z_r <= zflag;
        end else begin
          count <= count - CW'(1);
          if (diff[WIDTH+1]) begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end else begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Q           = q_r;
  assign bus.R           = r_r;
  assign bus.div_by_zero = z_r;
endmodule

// File: tb/tb_alu_div_seq.sv
// tb/tb_alu_div_seq.sv - scoreboard bench for alu_div_seq
module tb_alu_div_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           t;
  } exp_t;
  exp_t sb[$];

  alu_div_seq_if #(.WIDTH(W)) bus ();
  alu_div_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("Q", bus.Q, e.q);
        chk("R", bus.R, e.r);
        chk("div_by_zero", bus.div_by_zero, e.z);
        chk("done_cycle", cyc, e.t);
        if (!e.z) begin
          chk("identity", 32'(bus.Q) * 32'(dut.dvs) + 32'(bus.R), 32'(dut.quo) === 'x ? 0 : 32'(bus.Q) * 32'(dut.dvs) + 32'(bus.R));
        end
      end
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    exp_t e;
    while (bus.busy || bus.done) @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    if (push) begin
      e.q = (b == 0) ? '1 : a / b;
      e.r = (b == 0) ? a : a % b;
      e.z = (b == 0);
      e.t = cyc + 1 + ((b == 0) ? 1 : W + 1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
    launch(a, b, 1'b1);
    wait_drain();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_Q", bus.Q, 0);
    chk("rst_R", bus.R, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    run_div(200, 7);
    repeat (3) @(negedge clk);
    chk("hold_Q", bus.Q, 28);
    chk("hold_R", bus.R, 4);
    chk("hold_busy", bus.busy, 0);

    run_div(255, 1);
    run_div(5, 10);
    run_div(0, 3);
    run_div(77, 0);
    run_div(77, 9);

    launch(100, 9, 1'b1);
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      if (c == 3 || c == 8) begin
        bus.A = 1; bus.B = 1; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
      end
    end
    wait_drain();
    repeat (2) @(negedge clk);
    chk("ignored_busy", bus.busy, 0);
    chk("ignored_Q", bus.Q, 11);

    launch(200, 7, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_Q", bus.Q, 0);
    chk("arst_R", bus.R, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_div(50, 6);

    for (int a = 0; a < 256; a++) begin
      run_div(W'(a), W'($urandom_range(1, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    chk("global_timeout", 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end
endmodule
